cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
- Hardwired sequencer for the 8-bit datapath: register file (R1-R4, T1-T4), address register file (PC/AR/SP), 16-bit IR and ALU.
- Fetches a 16-bit instruction as two byte reads (low byte, then high byte), then executes it in one cycle.
- Drives every datapath control bus and waits on a memory-ready handshake, with a timeout.
- Sits between instruction memory and the datapath; contains no data registers of its own beyond its state and counters.

Parameters:
- WAIT_LIMIT, 15: maximum consecutive MemReady-low cycles tolerated in a fetch state before a bus fault.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset.
- IR_Q  in  16  current IR contents.
- ALU_Flag  in  4  ALU flags {Z,C,N,O}; bit3 = Z.
- MemReady  in  1  memory data valid this cycle.
- Mem_RD  out  1  memory read strobe; address is ARF OutB.
- IR_En  out  1  IR enable.
- IR_LH  out  1  0 = low byte, 1 = high byte.
- IR_FunSel  out  2  IR function select.
- RF_O1Sel  out  3  RF output 1 select.
- RF_O2Sel  out  3  RF output 2 select.
- RF_FunSel  out  2  RF function select.
- RF_RSel  out  4  R1-R4 enables, active-low, one bit per register.
- RF_TSel  out  4  T1-T4 enables, active-low.
- ARF_OutBSel  out  2  ARF output B select.
- ARF_FunSel  out  2  ARF function select.
- ARF_RegSel  out  4  enables, active-low; bit0 PC, bit1 AR, bit2 SP, bit3 unused.
- ALU_FunSel  out  4  ALU operation.
- MuxASel  out  1  RF input source: 0 = ALU out, 1 = IR[7:0].
- MuxBSel  out  1  ARF input source: 0 = ALU out, 1 = IR[7:0].
- Halted  out  1  core stopped.
- Fault  out  1  stop was caused by a memory timeout.
- State  out  3  current state code, for debug.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: while RST is high, State = INIT(0) and the wait counter = 0.
  - All enables inactive: IR_En=0, RF_RSel=RF_TSel=ARF_RegSel=4'b1111, Mem_RD=0.
  - All selects and FunSels = 0; Halted=0, Fault=0.
- Outputs are combinational decodes of State and IR_Q. Halted and Fault are registered.
- FunSel encoding for IR/RF/ARF: 0 = clear, 1 = load, 2 = decrement, 3 = increment.
- States and encodings: INIT=0, FETCH_L=1, FETCH_H=2, EXEC=3, HALT=4.
- INIT (first cycle after reset release):
  - Clear PC, AR, SP: ARF_FunSel=0, ARF_RegSel=4'b1000.
  - Clear all of R1-R4 and T1-T4: RF_FunSel=0, RSel=TSel=4'b0000.
  - Next state: FETCH_L.
- FETCH_L: ARF_OutBSel=3 (PC), Mem_RD=1.
  - If MemReady=1: IR_En=1, IR_LH=0, IR_FunSel=1; PC increments (ARF_FunSel=3, ARF_RegSel=4'b1110); next FETCH_H.
  - If MemReady=0: hold state, all enables inactive, wait counter +1.
- FETCH_H: same as FETCH_L with IR_LH=1; next EXEC.
- Wait counter: clears on every state transition.
  - If it reaches WAIT_LIMIT while MemReady is still low, next state = HALT and Fault is set.
  - MemReady=1 in the limit cycle takes priority: normal advance, no fault.
- Instruction decode: opcode = IR_Q[15:12]; Rd = IR_Q[11:10]; Rs = IR_Q[9:8]; imm = IR_Q[7:0].
  - R-select: RF_O1Sel = 4+Rd, RF_O2Sel = 4+Rs, RF_RSel = ~(1<<Rd).
- EXEC, one cycle, then FETCH_L unless stated otherwise:
  - 0x0 NOP: no enables.
  - 0x1 LDI: Rd <= imm (MuxASel=1, RF_FunSel=1).
  - 0x2 ADD, 0x3 SUB, 0x4 AND, 0x5 OR, 0x6 XOR: Rd <= Rd op Rs.
    - ALU_FunSel = 0100, 0101, 0111, 1000, 1010 respectively.
    - MuxASel=0, RF_FunSel=1.
  - 0x7 INC / 0x8 DEC: RF_FunSel = 3 / 2 on Rd.
  - 0x9 BRA: PC <= imm (MuxBSel=1, ARF_FunSel=1, ARF_RegSel=4'b1110).
  - 0xA BZ: as BRA only if ALU_Flag[3]=1; otherwise no enables.
  - 0xF HLT: next state HALT; Halted set.
  - 0xB-0xE: executed as NOP.
- HALT: all enables inactive; Halted=1; no exit except RST.
- Reset mid-operation: immediate return to INIT and the reset output values. A partially fetched IR is not cleared, but it is overwritten by the next fetch.
- PC wrap-around: incrementing PC from 8'hFF wraps to 8'h00, with no special handling.

Test Plan:
- Reset, release -> one INIT cycle: ARF_RegSel=4'b1000, RSel=TSel=0000, FunSel=0. Then FETCH_L with Mem_RD=1, ARF_OutBSel=3.
- MemReady=1 throughout, IR_Q=16'h1C5A -> FETCH_L, FETCH_H, EXEC. EXEC has RF_RSel=4'b0111, MuxASel=1, RF_FunSel=1. PC incremented twice, instruction takes 3 cycles.
- IR_Q=16'h2600 (ADD R2,R3) -> EXEC: ALU_FunSel=0100, O1Sel=5, O2Sel=6, RF_RSel=4'b1101.
- BZ 16'hA040 with ALU_Flag=4'b1000 -> ARF_RegSel=4'b1110, MuxBSel=1, ARF_FunSel=1. Same instruction with ALU_Flag=0 -> ARF_RegSel=4'b1111.
- MemReady low for 3 cycles in FETCH_L -> state held, IR_En=0 throughout. MemReady low for 15 cycles -> HALT, Halted=1, Fault=1.
- IR_Q=16'hF000 -> HALT with Fault=0 and stays there for 20 cycles. RST asserted mid-FETCH_H -> State=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_control_unit.sv
// Hardwired sequencer: two-byte instruction fetch, single-cycle execute, timeout-to-halt on a stuck memory.
// Latency: 3 cycles per instruction with MemReady high (FETCH_L, FETCH_H, EXEC); control outputs are combinational.
// Backpressure: MemReady low holds a fetch state with all enables off; WAIT_LIMIT consecutive lows -> HALT with Fault.
module cpu_control_unit #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] IR_Q,
  input  logic [3:0]  ALU_Flag,
  input  logic        MemReady,
  output logic        Mem_RD,
  output logic        IR_En,
  output logic        IR_LH,
  output logic [1:0]  IR_FunSel,
  output logic [2:0]  RF_O1Sel,
  output logic [2:0]  RF_O2Sel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [1:0]  ARF_OutBSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RegSel,
  output logic [3:0]  ALU_FunSel,
  output logic        MuxASel,
  output logic        MuxBSel,
  output logic        Halted,
  output logic        Fault,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH_L = 3'd1,
    S_FETCH_H = 3'd2,
    S_EXEC    = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  // Last counter value before the fault fires: the WAIT_LIMIT-th low cycle times out.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_LIMIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;

  logic [3:0] opcode;
  logic [1:0] rd;
  logic [1:0] rs;
  logic [3:0] rd_wr_sel;
  logic       unused_bits;

  assign opcode    = IR_Q[15:12];
  assign rd        = IR_Q[11:10];
  assign rs        = IR_Q[9:8];
  assign rd_wr_sel = ~(4'b0001 << rd);
  // The immediate goes straight to the datapath muxes; only Z of the flags matters here.
  assign unused_bits = ^{IR_Q[7:0], ALU_Flag[2:0]};

  assign State  = state_q;
  assign Halted = halted_q;
  assign Fault  = fault_q;

  // State, wait counter and sticky status flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_INIT;
      wait_cnt_q <= '0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  // Next-state and control decode; reset forces every output to its idle value.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    halted_d    = halted_q;
    fault_d     = fault_q;
    Mem_RD      = 1'b0;
    IR_En       = 1'b0;
    IR_LH       = 1'b0;
    IR_FunSel   = 2'd0;
    RF_O1Sel    = 3'd0;
    RF_O2Sel    = 3'd0;
    RF_FunSel   = 2'd0;
    RF_RSel     = 4'b1111;
    RF_TSel     = 4'b1111;
    ARF_OutBSel = 2'd0;
    ARF_FunSel  = 2'd0;
    ARF_RegSel  = 4'b1111;
    ALU_FunSel  = 4'd0;
    MuxASel     = 1'b0;
    MuxBSel     = 1'b0;
    if (!RST) begin
      case (state_q)
        S_INIT: begin
          ARF_RegSel = 4'b1000;
          RF_RSel    = 4'b0000;
          RF_TSel    = 4'b0000;
          state_d    = S_FETCH_L;
          wait_cnt_d = '0;
        end
        S_FETCH_L, S_FETCH_H: begin
          ARF_OutBSel = 2'd3;
          Mem_RD      = 1'b1;
          IR_LH       = (state_q == S_FETCH_H);
          if (MemReady) begin
            IR_En      = 1'b1;
            IR_FunSel  = 2'd1;
            ARF_FunSel = 2'd3;
            ARF_RegSel = 4'b1110;
            state_d    = (state_q == S_FETCH_L) ? S_FETCH_H : S_EXEC;
            wait_cnt_d = '0;
          end else if (wait_cnt_q == LAST_WAIT) begin
            state_d    = S_HALT;
            wait_cnt_d = '0;
            halted_d   = 1'b1;
            fault_d    = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end
        S_EXEC: begin
          RF_O1Sel   = {1'b1, rd};
          RF_O2Sel   = {1'b1, rs};
          state_d    = S_FETCH_L;
          wait_cnt_d = '0;
          case (opcode)
            4'h1: begin
              MuxASel   = 1'b1;
              RF_FunSel = 2'd1;
              RF_RSel   = rd_wr_sel;
            end
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
              case (opcode)
                4'h2:    ALU_FunSel = 4'b0100;
                4'h3:    ALU_FunSel = 4'b0101;
                4'h4:    ALU_FunSel = 4'b0111;
                4'h5:    ALU_FunSel = 4'b1000;
                default: ALU_FunSel = 4'b1010;
              endcase
              RF_FunSel = 2'd1;
              RF_RSel   = rd_wr_sel;
            end
            4'h7: begin
              RF_FunSel = 2'd3;
              RF_RSel   = rd_wr_sel;
            end
            4'h8: begin
              RF_FunSel = 2'd2;
              RF_RSel   = rd_wr_sel;
            end
            4'h9: begin
              MuxBSel    = 1'b1;
              ARF_FunSel = 2'd1;
              ARF_RegSel = 4'b1110;
            end
            4'hA: begin
              if (ALU_Flag[3]) begin
                MuxBSel    = 1'b1;
                ARF_FunSel = 2'd1;
                ARF_RegSel = 4'b1110;
              end
            end
            4'hF: begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end
            default: ;
          endcase
        end
        S_HALT: begin
          halted_d = 1'b1;
        end
        default: begin
          state_d = S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: reset, fetch/execute decode, memory wait/timeout, halt, async reset.
// Inputs change just after a falling edge; outputs are sampled 1 ns later, well away from the rising edge.
// Every expected value below is hand-derived from the instruction encoding and state sequence.
module tb_cpu_control_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] IR_Q = 16'h0000;
  logic [3:0]  ALU_Flag = 4'b0000;
  logic        MemReady = 1'b0;
  logic        Mem_RD, IR_En, IR_LH, MuxASel, MuxBSel, Halted, Fault;
  logic [1:0]  IR_FunSel, RF_FunSel, ARF_OutBSel, ARF_FunSel;
  logic [2:0]  RF_O1Sel, RF_O2Sel, State;
  logic [3:0]  RF_RSel, RF_TSel, ARF_RegSel, ALU_FunSel;

  int checks = 0;
  int errors = 0;

  cpu_control_unit #(.WAIT_LIMIT(15), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .IR_Q(IR_Q), .ALU_Flag(ALU_Flag), .MemReady(MemReady),
    .Mem_RD(Mem_RD), .IR_En(IR_En), .IR_LH(IR_LH), .IR_FunSel(IR_FunSel),
    .RF_O1Sel(RF_O1Sel), .RF_O2Sel(RF_O2Sel), .RF_FunSel(RF_FunSel),
    .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ARF_OutBSel(ARF_OutBSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .ALU_FunSel(ALU_FunSel),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .Halted(Halted), .Fault(Fault), .State(State)
  );

  always #5 CLK = ~CLK;

  task automatic next_cycle();
    @(negedge CLK);
    #1;
  endtask

  // Reset, release, step through INIT; returns sampling inside FETCH_L.
  task automatic to_fetch_l();
    RST = 1'b1; MemReady = 1'b0; IR_Q = 16'h0000; ALU_Flag = 4'b0000;
    @(negedge CLK);
    RST = 1'b0;
    next_cycle();
  endtask

  // From FETCH_L, fetch ir with memory always ready; returns sampling inside EXEC.
  task automatic exec_instr(input logic [15:0] ir);
    IR_Q = ir; MemReady = 1'b1;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    next_cycle();
    checks++; if (State !== 3'd0) begin errors++; $display("FAIL rst_state got %0d want 0", State); end
    checks++; if ({IR_En, Mem_RD, Halted, Fault} !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b want 0000", {IR_En, Mem_RD, Halted, Fault}); end
    checks++; if ({RF_RSel, RF_TSel, ARF_RegSel} !== 12'hFFF) begin errors++; $display("FAIL rst_enables got %h want fff", {RF_RSel, RF_TSel, ARF_RegSel}); end
    checks++; if ({ARF_FunSel, RF_FunSel, IR_FunSel, ALU_FunSel, ARF_OutBSel} !== 12'h000) begin errors++; $display("FAIL rst_funsels got %h want 000", {ARF_FunSel, RF_FunSel, IR_FunSel, ALU_FunSel, ARF_OutBSel}); end
    RST = 1'b0;
    #1;
    checks++; if (State !== 3'd0) begin errors++; $display("FAIL init_state got %0d want 0", State); end
    checks++; if (ARF_RegSel !== 4'b1000) begin errors++; $display("FAIL init_arf_regsel got %b want 1000", ARF_RegSel); end
    checks++; if ({RF_RSel, RF_TSel} !== 8'h00) begin errors++; $display("FAIL init_rf_sel got %h want 00", {RF_RSel, RF_TSel}); end
    checks++; if ({RF_FunSel, ARF_FunSel} !== 4'b0000) begin errors++; $display("FAIL init_funsel got %b want 0000", {RF_FunSel, ARF_FunSel}); end
    next_cycle();
    checks++; if (State !== 3'd1) begin errors++; $display("FAIL fetchl_state got %0d want 1", State); end
    checks++; if ({Mem_RD, ARF_OutBSel} !== 3'b111) begin errors++; $display("FAIL fetchl_read got %b want 111", {Mem_RD, ARF_OutBSel}); end
  endtask

  task automatic test_ldi();
    int pc_incs = 0;
    IR_Q = 16'h1C5A; MemReady = 1'b1;
    #1;
    checks++; if ({IR_En, IR_LH, IR_FunSel} !== 4'b1001) begin errors++; $display("FAIL ldi_fetchl_ir got %b want 1001", {IR_En, IR_LH, IR_FunSel}); end
    if (ARF_FunSel == 2'd3 && ARF_RegSel == 4'b1110) pc_incs++;
    next_cycle();
    checks++; if ({State, IR_En, IR_LH} !== 5'b01011) begin errors++; $display("FAIL ldi_fetchh got %b want 01011", {State, IR_En, IR_LH}); end
    if (ARF_FunSel == 2'd3 && ARF_RegSel == 4'b1110) pc_incs++;
    next_cycle();
    checks++; if (State !== 3'd3) begin errors++; $display("FAIL ldi_exec_state got %0d want 3", State); end
    checks++; if ({RF_RSel, MuxASel, RF_FunSel} !== 7'b0111_1_01) begin errors++; $display("FAIL ldi_exec got %b want 0111101", {RF_RSel, MuxASel, RF_FunSel}); end
    if (ARF_FunSel == 2'd3 && ARF_RegSel == 4'b1110) pc_incs++;
    next_cycle();
    checks++; if (State !== 3'd1) begin errors++; $display("FAIL ldi_back_to_fetch got %0d want 1", State); end
    checks++; if (pc_incs !== 2) begin errors++; $display("FAIL ldi_pc_incs got %0d want 2", pc_incs); end
  endtask

  task automatic test_add();
    exec_instr(16'h2600);
    checks++; if (ALU_FunSel !== 4'b0100) begin errors++; $display("FAIL add_alu got %b want 0100", ALU_FunSel); end
    checks++; if ({RF_O1Sel, RF_O2Sel} !== 6'o56) begin errors++; $display("FAIL add_osel got %o want 56", {RF_O1Sel, RF_O2Sel}); end
    checks++; if ({RF_RSel, MuxASel, RF_FunSel, RF_TSel} !== 11'b1101_0_01_1111) begin errors++; $display("FAIL add_write got %b want 11010011111", {RF_RSel, MuxASel, RF_FunSel, RF_TSel}); end
    next_cycle();
  endtask

  task automatic test_alu_ops();
    logic [3:0] exp_alu [4] = '{4'b0101, 4'b0111, 4'b1000, 4'b1010};
    for (int i = 0; i < 4; i++) begin
      exec_instr({4'(3 + i), 4'b0011, 8'h00});
      checks++; if ({ALU_FunSel, RF_RSel, RF_FunSel, RF_O2Sel} !== {exp_alu[i], 4'b1110, 2'd1, 3'd7})
        begin errors++; $display("FAIL alu_op%0d got %b want %b", 3 + i, {ALU_FunSel, RF_RSel, RF_FunSel, RF_O2Sel}, {exp_alu[i], 4'b1110, 2'd1, 3'd7}); end
      next_cycle();
    end
  endtask

  task automatic test_inc_dec();
    exec_instr(16'h7800);
    checks++; if ({RF_RSel, RF_FunSel} !== 6'b1011_11) begin errors++; $display("FAIL inc got %b want 101111", {RF_RSel, RF_FunSel}); end
    next_cycle();
    exec_instr(16'h8400);
    checks++; if ({RF_RSel, RF_FunSel} !== 6'b1101_10) begin errors++; $display("FAIL dec got %b want 110110", {RF_RSel, RF_FunSel}); end
    next_cycle();
  endtask

  task automatic test_branch();
    exec_instr(16'h9033);
    checks++; if ({ARF_RegSel, MuxBSel, ARF_FunSel, RF_RSel} !== 11'b1110_1_01_1111) begin errors++; $display("FAIL bra got %b want 11101011111", {ARF_RegSel, MuxBSel, ARF_FunSel, RF_RSel}); end
    next_cycle();
    ALU_Flag = 4'b1000;
    exec_instr(16'hA040);
    checks++; if ({ARF_RegSel, MuxBSel, ARF_FunSel} !== 7'b1110_1_01) begin errors++; $display("FAIL bz_taken got %b want 1110101", {ARF_RegSel, MuxBSel, ARF_FunSel}); end
    next_cycle();
    ALU_Flag = 4'b0000;
    exec_instr(16'hA040);
    checks++; if (ARF_RegSel !== 4'b1111) begin errors++; $display("FAIL bz_not_taken got %b want 1111", ARF_RegSel); end
    next_cycle();
    ALU_Flag = 4'b0111;
    exec_instr(16'hA040);
    checks++; if (ARF_RegSel !== 4'b1111) begin errors++; $display("FAIL bz_other_flags got %b want 1111", ARF_RegSel); end
    next_cycle();
    ALU_Flag = 4'b0000;
  endtask

  task automatic test_nop();
    exec_instr(16'hC3FF);
    checks++; if ({RF_RSel, RF_TSel, ARF_RegSel, IR_En} !== 13'b1111_1111_1111_0) begin errors++; $display("FAIL nop_c got %b want 1111111111110", {RF_RSel, RF_TSel, ARF_RegSel, IR_En}); end
    next_cycle();
    checks++; if (State !== 3'd1) begin errors++; $display("FAIL nop_next got %0d want 1", State); end
  endtask

  task automatic test_wait();
    MemReady = 1'b0; IR_Q = 16'h0000;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({State, IR_En, Mem_RD, ARF_RegSel} !== 9'b001_0_1_1111) begin errors++; $display("FAIL wait_hold%0d got %b want 001011111", i, {State, IR_En, Mem_RD, ARF_RegSel}); end
      next_cycle();
    end
    MemReady = 1'b1;
    next_cycle();
    MemReady = 1'b0;
    checks++; if (State !== 3'd2) begin errors++; $display("FAIL wait_advance got %0d want 2", State); end
    repeat (14) next_cycle();
    MemReady = 1'b1;
    next_cycle();
    checks++; if ({State, Fault, Halted} !== 5'b011_0_0) begin errors++; $display("FAIL wait_limit_ready got %b want 01100", {State, Fault, Halted}); end
    next_cycle();
  endtask

  task automatic test_timeout();
    MemReady = 1'b0;
    #1;
    repeat (14) next_cycle();
    checks++; if ({State, Fault} !== 4'b001_0) begin errors++; $display("FAIL timeout_14 got %b want 0010", {State, Fault}); end
    next_cycle();
    checks++; if ({State, Halted, Fault, Mem_RD} !== 6'b100_1_1_0) begin errors++; $display("FAIL timeout_15 got %b want 100110", {State, Halted, Fault, Mem_RD}); end
    #2 RST = 1'b1;
    #1;
    checks++; if ({State, Halted, Fault} !== 5'b000_0_0) begin errors++; $display("FAIL timeout_async_rst got %b want 00000", {State, Halted, Fault}); end
  endtask

  task automatic test_hlt();
    to_fetch_l();
    exec_instr(16'hF000);
    checks++; if ({State, RF_RSel, ARF_RegSel} !== 11'b011_1111_1111) begin errors++; $display("FAIL hlt_exec got %b want 01111111111", {State, RF_RSel, ARF_RegSel}); end
    next_cycle();
    checks++; if ({State, Halted, Fault} !== 5'b100_1_0) begin errors++; $display("FAIL hlt_enter got %b want 10010", {State, Halted, Fault}); end
    for (int i = 0; i < 20; i++) begin
      MemReady = i[0];
      next_cycle();
      checks++; if ({State, Halted, Fault, Mem_RD, IR_En} !== 7'b100_1_0_0_0) begin errors++; $display("FAIL hlt_stay%0d got %b want 1001000", i, {State, Halted, Fault, Mem_RD, IR_En}); end
    end
  endtask

  task automatic test_reset_mid();
    to_fetch_l();
    IR_Q = 16'h1234; MemReady = 1'b1;
    next_cycle();
    MemReady = 1'b0;
    #1;
    checks++; if (State !== 3'd2) begin errors++; $display("FAIL mid_in_fetchh got %0d want 2", State); end
    #1 RST = 1'b1;
    #1;
    checks++; if ({State, IR_En, Mem_RD, RF_RSel} !== 9'b000_0_0_1111) begin errors++; $display("FAIL mid_async_rst got %b want 000001111", {State, IR_En, Mem_RD, RF_RSel}); end
    to_fetch_l();
    exec_instr(16'h1C5A);
    checks++; if ({State, RF_RSel, MuxASel} !== 8'b011_0111_1) begin errors++; $display("FAIL mid_recover got %b want 01101111", {State, RF_RSel, MuxASel}); end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_add();
    test_alu_ops();
    test_inc_dec();
    test_branch();
    test_nop();
    test_wait();
    test_timeout();
    test_hlt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
